hazard3_trigger_break_ctrl: RTL and testbench



---
 rtl/hazard3_trigger_break_ctrl_pkg.sv | 16 +
 rtl/hazard3_trigger_break_ctrl.sv | 83 ++++++++
 tb/tb_hazard3_trigger_break_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hazard3_trigger_break_ctrl_pkg.sv
// rtl/hazard3_trigger_break_ctrl_pkg.sv - shared constants and state type for the trigger break sequencer
package hazard3_trigger_break_ctrl_pkg;

    // Trap cause codes reported alongside a trigger breakpoint
    localparam int CSR_MCAUSE_BREAKPOINT  = 3;
    localparam int CSR_DCSR_CAUSE_TRIGGER = 2;

    // Sequencer states: capture, request outstanding, handler running, step-past window
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PEND     = 2'd1,
        ST_WAIT_RET = 2'd2,
        ST_SUPPRESS = 2'd3
    } brk_state_t;

endpackage

// File: rtl/hazard3_trigger_break_ctrl.sv
// rtl/hazard3_trigger_break_ctrl.sv - sequences trigger breakpoints into the trap/debug entry path
module hazard3_trigger_break_ctrl
    import hazard3_trigger_break_ctrl_pkg::*;
#(
    parameter int W_ADDR             = 32,
    parameter int MCAUSE_BREAKPOINT  = CSR_MCAUSE_BREAKPOINT,
    parameter int DCSR_CAUSE_TRIGGER = CSR_DCSR_CAUSE_TRIGGER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig_break,
    input  logic              trig_break_d_mode,
    input  logic              d_pc_valid,
    input  logic [W_ADDR-1:0] d_pc,
    input  logic              d_stall,
    input  logic              x_flush,
    input  logic              trap_ack,
    input  logic              trap_resume,
    output logic              d_hold,
    output logic              break_req,
    output logic              break_d_mode,
    output logic [3:0]        break_cause,
    output logic [W_ADDR-1:0] break_pc
);

    brk_state_t        state_q, state_d;
    logic              break_req_q;
    logic              break_d_mode_q;
    logic [W_ADDR-1:0] break_pc_q;

    logic qual;
    logic capture;

    // A flush in the same cycle means the decode instruction is already dead
    assign qual    = trig_break && d_pc_valid && !x_flush;
    assign capture = (state_q == ST_IDLE) && qual;

    // Next-state selection; trap_ack outranks a flush in PEND, and mret/dret outranks a flush in WAIT_RET
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (qual) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (trap_ack)     state_d = ST_WAIT_RET;
                else if (x_flush) state_d = ST_IDLE;
            end
            ST_WAIT_RET: begin
                if (trap_resume) state_d = ST_SUPPRESS;
            end
            ST_SUPPRESS: begin
                if (x_flush || (d_pc_valid && !d_stall)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, registered request and captured breakpoint context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            break_req_q    <= 1'b0;
            break_d_mode_q <= 1'b0;
            break_pc_q     <= '0;
        end else begin
            state_q     <= state_d;
            break_req_q <= (state_d == ST_PEND);
            if (capture) begin
                break_pc_q     <= d_pc;
                break_d_mode_q <= trig_break_d_mode;
            end
        end
    end

    // Hold decode in the qualifying cycle itself so the matching instruction never advances
    assign d_hold       = capture || (state_q == ST_PEND);
    assign break_req    = break_req_q;
    assign break_d_mode = break_d_mode_q;
    assign break_pc     = break_pc_q;
    assign break_cause  = break_d_mode_q ? 4'(DCSR_CAUSE_TRIGGER) : 4'(MCAUSE_BREAKPOINT);

endmodule

// File: tb/tb_hazard3_trigger_break_ctrl.sv
// tb/tb_hazard3_trigger_break_ctrl.sv - vector table and scoreboard bench for the trigger break sequencer
module tb_hazard3_trigger_break_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig_break, trig_break_d_mode, d_pc_valid, d_stall, x_flush, trap_ack, trap_resume;
    logic [31:0] d_pc;
    logic        d_hold, break_req, break_d_mode;
    logic [3:0]  break_cause;
    logic [31:0] break_pc;

    hazard3_trigger_break_ctrl #(
        .W_ADDR(32), .MCAUSE_BREAKPOINT(3), .DCSR_CAUSE_TRIGGER(2)
    ) dut (
        .clk(clk), .rst(rst),
        .trig_break(trig_break), .trig_break_d_mode(trig_break_d_mode),
        .d_pc_valid(d_pc_valid), .d_pc(d_pc), .d_stall(d_stall),
        .x_flush(x_flush), .trap_ack(trap_ack), .trap_resume(trap_resume),
        .d_hold(d_hold), .break_req(break_req), .break_d_mode(break_d_mode),
        .break_cause(break_cause), .break_pc(break_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hold;
        logic        req;
        logic        dm;
        logic [3:0]  cause;
        logic [31:0] pc;
    } outs_t;

    typedef struct {
        string       name;
        logic        trig, dmode, valid;
        logic [31:0] pc;
        logic        stall, flush, ack, resume;
        outs_t       exp;
    } vec_t;

    vec_t  vecs[$];
    outs_t sb_q[$];
    string sb_name[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic add(input string name, input logic trig, input logic dmode, input logic valid,
                       input logic [31:0] pc, input logic stall, input logic flush, input logic ack,
                       input logic resume, input logic hold, input logic req, input logic dm,
                       input logic [3:0] cause, input logic [31:0] bpc);
        vec_t v;
        v.name = name; v.trig = trig; v.dmode = dmode; v.valid = valid; v.pc = pc;
        v.stall = stall; v.flush = flush; v.ack = ack; v.resume = resume;
        v.exp = '{hold: hold, req: req, dm: dm, cause: cause, pc: bpc};
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        trig_break = 0; trig_break_d_mode = 0; d_pc_valid = 0; d_pc = 32'h0;
        d_stall = 0; x_flush = 0; trap_ack = 0; trap_resume = 0;
    endtask

    task automatic check_out();
        outs_t act, exp;
        string nm;
        act = '{hold: d_hold, req: break_req, dm: break_d_mode, cause: break_cause, pc: break_pc};
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty: got output with no expected entry");
            return;
        end
        exp = sb_q.pop_front();
        nm  = sb_name.pop_front();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got hold=%0b req=%0b dm=%0b cause=%0d pc=%h, expected hold=%0b req=%0b dm=%0b cause=%0d pc=%h",
                     nm, act.hold, act.req, act.dm, act.cause, act.pc,
                     exp.hold, exp.req, exp.dm, exp.cause, exp.pc);
        end
    endtask

    initial begin
        //   name              trig dm val pc            stl fl ack res  hold req dm cause bpc
        add("a_qual",          1, 0, 1, 32'h1000, 0, 0, 0, 0,  1, 0, 0, 3, 32'h0);
        add("a_pend1",         0, 0, 1, 32'h1004, 0, 0, 0, 0,  1, 1, 0, 3, 32'h1000);
        add("a_pend2",         0, 0, 1, 32'h1004, 0, 0, 0, 0,  1, 1, 0, 3, 32'h1000);
        add("a_ack",           0, 0, 1, 32'h1004, 0, 0, 1, 0,  1, 1, 0, 3, 32'h1000);
        add("a_wait",          0, 0, 0, 32'h0,    0, 0, 0, 0,  0, 0, 0, 3, 32'h1000);
        add("a_wait_trig",     1, 0, 1, 32'h2000, 0, 0, 0, 0,  0, 0, 0, 3, 32'h1000);
        add("a_wait_flush",    0, 0, 0, 32'h0,    0, 1, 0, 0,  0, 0, 0, 3, 32'h1000);
        add("a_resume",        1, 0, 1, 32'h1000, 1, 0, 0, 1,  0, 0, 0, 3, 32'h1000);
        add("a_sup_stall",     1, 0, 1, 32'h1000, 1, 0, 0, 0,  0, 0, 0, 3, 32'h1000);
        add("a_sup_adv",       1, 0, 1, 32'h1000, 0, 0, 0, 0,  0, 0, 0, 3, 32'h1000);
        add("a_next_qual",     1, 0, 1, 32'h1004, 0, 0, 0, 0,  1, 0, 0, 3, 32'h1000);
        add("a_next_pend",     0, 0, 1, 32'h1008, 0, 0, 0, 0,  1, 1, 0, 3, 32'h1004);
        add("a_next_ack",      0, 0, 1, 32'h1008, 0, 0, 1, 0,  1, 1, 0, 3, 32'h1004);
        add("resume2",         0, 0, 0, 32'h0,    0, 0, 0, 1,  0, 0, 0, 3, 32'h1004);
        add("sup_flush",       1, 0, 1, 32'h5000, 0, 1, 0, 0,  0, 0, 0, 3, 32'h1004);
        add("b_qual",          1, 1, 1, 32'h1000, 0, 0, 0, 0,  1, 0, 0, 3, 32'h1004);
        add("b_pend",          0, 0, 1, 32'h1004, 0, 0, 0, 0,  1, 1, 1, 2, 32'h1000);
        add("b_flush",         0, 0, 1, 32'h1004, 0, 1, 0, 0,  1, 1, 1, 2, 32'h1000);
        add("b_idle",          0, 0, 0, 32'h0,    0, 0, 0, 0,  0, 0, 1, 2, 32'h1000);
        add("b_qual_flush",    1, 0, 1, 32'h6000, 0, 1, 0, 0,  0, 0, 1, 2, 32'h1000);
        add("b_trig_novalid",  1, 0, 0, 32'h6000, 0, 0, 0, 0,  0, 0, 1, 2, 32'h1000);
        add("c_qual_stall",    1, 0, 1, 32'h3000, 1, 0, 0, 0,  1, 0, 1, 2, 32'h1000);
        add("c_pend",          0, 0, 1, 32'h3000, 1, 0, 0, 0,  1, 1, 0, 3, 32'h3000);
        add("c_ack_flush",     0, 0, 1, 32'h3000, 0, 1, 1, 0,  1, 1, 0, 3, 32'h3000);
        add("c_wait",          0, 0, 0, 32'h0,    0, 0, 0, 0,  0, 0, 0, 3, 32'h3000);
        add("c_resume",        0, 0, 0, 32'h0,    0, 0, 0, 1,  0, 0, 0, 3, 32'h3000);
        add("c_sup_novalid",   1, 0, 0, 32'h0,    0, 0, 0, 0,  0, 0, 0, 3, 32'h3000);
        add("c_sup_adv",       0, 0, 1, 32'h3004, 0, 0, 0, 0,  0, 0, 0, 3, 32'h3000);
        add("d_resume_idle",   0, 0, 0, 32'h0,    0, 0, 0, 1,  0, 0, 0, 3, 32'h3000);
        add("d_qual",          1, 1, 1, 32'h4000, 0, 0, 0, 0,  1, 0, 0, 3, 32'h3000);
        add("d_pend",          0, 0, 1, 32'h4004, 0, 0, 0, 0,  1, 1, 1, 2, 32'h4000);
        add("d_pend_resume",   0, 0, 1, 32'h4004, 0, 0, 0, 1,  1, 1, 1, 2, 32'h4000);
        add("d_pend2",         0, 0, 1, 32'h4004, 0, 0, 0, 0,  1, 1, 1, 2, 32'h4000);

        // Reset state
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back('{hold: 1'b0, req: 1'b0, dm: 1'b0, cause: 4'd3, pc: 32'h0});
        sb_name.push_back("reset_state");
        check_out();
        @(negedge clk);
        rst = 1'b0;

        // Table: drive after the edge, compare mid-cycle
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            trig_break  = vecs[i].trig;  trig_break_d_mode = vecs[i].dmode;
            d_pc_valid  = vecs[i].valid; d_pc              = vecs[i].pc;
            d_stall     = vecs[i].stall; x_flush           = vecs[i].flush;
            trap_ack    = vecs[i].ack;   trap_resume       = vecs[i].resume;
            sb_q.push_back(vecs[i].exp);
            sb_name.push_back(vecs[i].name);
            @(negedge clk);
            check_out();
        end

        // Asynchronous reset while PEND: outputs clear without a clock edge
        @(posedge clk);
        #1;
        drive_idle();
        #1;
        sb_q.push_back('{hold: 1'b1, req: 1'b1, dm: 1'b1, cause: 4'd2, pc: 32'h4000});
        sb_name.push_back("pend_before_rst");
        check_out();
        rst = 1'b1;
        #1;
        sb_q.push_back('{hold: 1'b0, req: 1'b0, dm: 1'b0, cause: 4'd3, pc: 32'h0});
        sb_name.push_back("async_rst_pend");
        check_out();
        @(negedge clk);
        rst = 1'b0;

        // Fresh request after reset is honoured
        @(posedge clk);
        #1;
        trig_break = 1; d_pc_valid = 1; d_pc = 32'h7000;
        sb_q.push_back('{hold: 1'b1, req: 1'b0, dm: 1'b0, cause: 4'd3, pc: 32'h0});
        sb_name.push_back("post_rst_qual");
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
        trig_break = 0;
        sb_q.push_back('{hold: 1'b1, req: 1'b1, dm: 1'b0, cause: 4'd3, pc: 32'h7000});
        sb_name.push_back("post_rst_pend");
        @(negedge clk);
        check_out();

        if (sb_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
